// File: rtl/riscv_pkg.sv
// riscv_pkg: shared LSU types, FSM states and access-size helpers
package riscv_pkg;
    typedef enum logic [1:0] {Byte_Access, Halfword_Access, Word_Access, Reserved} access_size_t;
    typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} lsu_state_t;
    function automatic logic [3:0] size_mask(input access_size_t s);
        return (s == Byte_Access) ? 4'b0001 : (s == Halfword_Access) ? 4'b0011 : 4'b1111;
    endfunction
endpackage

// File: rtl/riscv_lsu_align.sv
// riscv_lsu_align: store lane shift and byte enables per word, load extraction and extension
module riscv_lsu_align
    import riscv_pkg::*;
(
    input  logic [1:0]   i_off,
    input  access_size_t i_size,
    input  logic [31:0]  i_wdata,
    input  logic [63:0]  i_rdata,
    input  logic         i_zext,
    output logic [3:0]   o_be0,
    output logic [3:0]   o_be1,
    output logic [31:0]  o_wd0,
    output logic [31:0]  o_wd1,
    output logic [31:0]  o_ld
);
    logic [4:0]  w_bits;
    logic [7:0]  w_be;
    logic [63:0] w_wd;
    logic [31:0] w_sh;
    assign w_bits = {i_off, 3'b000};
    assign w_be   = {4'b0000, size_mask(i_size)} << i_off;
    assign w_wd   = {32'h0, i_wdata} << w_bits;
    assign w_sh   = 32'(i_rdata >> w_bits);
    assign o_be0  = w_be[3:0];
    assign o_be1  = w_be[7:4];
    assign o_wd0  = w_wd[31:0];
    assign o_wd1  = w_wd[63:32];
    assign o_ld   = (i_size == Byte_Access)     ? {{24{~i_zext & w_sh[7]}}, w_sh[7:0]} :
                    (i_size == Halfword_Access) ? {{16{~i_zext & w_sh[15]}}, w_sh[15:0]} : w_sh;
endmodule

// File: rtl/riscv_lsu_ctrl.sv
// riscv_lsu_ctrl: load/store FSM with misaligned splitting, response timeout and core stall
module riscv_lsu_ctrl
    import riscv_pkg::*;
#(
    parameter int MISALIGN_SPLIT = 1,
    parameter int TIMEOUT        = 255,
    parameter int TO_W           = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_req_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [1:0]  lsu_size_i,
    input  logic        lsu_wr_i,
    input  logic [31:0] lsu_wr_data_i,
    input  logic        lsu_zero_extnd_i,
    output logic        lsu_busy_o,
    output logic        lsu_done_o,
    output logic        lsu_err_o,
    output logic [31:0] lsu_rd_data_o,
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_wr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wr_data_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rd_data_i,
    input  logic        mem_err_i
);
    localparam int CW = (TO_W < 1) ? 1 : TO_W;
    lsu_state_t    r_state;
    lsu_state_t    w_next;
    access_size_t  r_size;
    logic [31:0]   r_addr;
    logic [31:0]   r_data;
    logic [31:0]   r_w0;
    logic [31:0]   r_rd;
    logic          r_wr;
    logic          r_zext;
    logic          r_split;
    logic          r_err;
    logic [CW-1:0] r_to;
    logic          w_mis;
    logic          w_req;
    logic          w_wait;
    logic          w_to_hit;
    logic          w_ok;
    logic [3:0]    w_be0;
    logic [3:0]    w_be1;
    logic [31:0]   w_wd0;
    logic [31:0]   w_wd1;
    logic [31:0]   w_ld;
    logic [63:0]   w_rd64;
    // a lane mask spilling past byte 3 means the access crosses a word boundary
    assign w_mis    = |(({4'b0000, size_mask(access_size_t'(lsu_size_i))} << lsu_addr_i[1:0]) >> 4);
    assign w_req    = (r_state == REQ0) || (r_state == REQ1);
    assign w_wait   = (r_state == WAIT0) || (r_state == WAIT1);
    assign w_to_hit = (TIMEOUT != 0) && !mem_rvalid_i && (r_to == CW'(TIMEOUT - 1));
    assign w_ok     = w_wait && mem_rvalid_i && !mem_err_i;
    assign w_rd64   = (r_state == WAIT1) ? {mem_rd_data_i, r_w0} : {32'h0, mem_rd_data_i};

    riscv_lsu_align u_align (
        .i_off   (r_addr[1:0]),
        .i_size  (r_size),
        .i_wdata (r_data),
        .i_rdata (w_rd64),
        .i_zext  (r_zext),
        .o_be0   (w_be0),
        .o_be1   (w_be1),
        .o_wd0   (w_wd0),
        .o_wd1   (w_wd1),
        .o_ld    (w_ld)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (lsu_req_i) w_next = (w_mis && MISALIGN_SPLIT == 0) ? DONE : REQ0;
            REQ0:    if (mem_gnt_i) w_next = WAIT0;
            WAIT0:   if (mem_rvalid_i || w_to_hit) w_next = (w_ok && r_split) ? REQ1 : DONE;
            REQ1:    if (mem_gnt_i) w_next = WAIT1;
            WAIT1:   if (mem_rvalid_i || w_to_hit) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_size  <= Byte_Access;
            r_addr  <= '0;
            r_data  <= '0;
            r_w0    <= '0;
            r_rd    <= '0;
            r_wr    <= 1'b0;
            r_zext  <= 1'b0;
            r_split <= 1'b0;
            r_err   <= 1'b0;
            r_to    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && lsu_req_i) begin
                r_addr  <= lsu_addr_i;
                r_size  <= access_size_t'(lsu_size_i);
                r_wr    <= lsu_wr_i;
                r_data  <= lsu_wr_data_i;
                r_zext  <= lsu_zero_extnd_i;
                r_split <= w_mis;
            end
            if (w_next == DONE && r_state != DONE) r_err <= (r_state == IDLE) || !w_ok;
            if (r_state == WAIT0 && mem_rvalid_i) r_w0 <= mem_rd_data_i;
            if (w_ok && !r_wr && w_next == DONE) r_rd <= w_ld;
            if (w_req && mem_gnt_i) r_to <= '0;
            else if (w_wait && !mem_rvalid_i) r_to <= r_to + CW'(1);
        end
    end

    assign lsu_busy_o    = (r_state == IDLE && lsu_req_i) || w_req || w_wait;
    assign lsu_done_o    = r_state == DONE;
    assign lsu_err_o     = (r_state == DONE) && r_err;
    assign lsu_rd_data_o = r_rd;
    assign mem_req_o     = w_req;
    assign mem_wr_o      = w_req && r_wr;
    assign mem_addr_o    = (r_state == REQ0) ? {r_addr[31:2], 2'b00} :
                           (r_state == REQ1) ? {r_addr[31:2] + 30'd1, 2'b00} : '0;
    assign mem_be_o      = (r_state == REQ0) ? w_be0 : (r_state == REQ1) ? w_be1 : '0;
    assign mem_wr_data_o = (r_state == REQ0) ? w_wd0 : (r_state == REQ1) ? w_wd1 : '0;
endmodule

// File: tb/tb_riscv_lsu_ctrl.sv
// tb_riscv_lsu_ctrl: directed scoreboard bench for the load/store controller
module tb_riscv_lsu_ctrl;
    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        wr;
        logic [31:0] wd;
    } req_t;
    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          lat;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_req_i;
    logic        r0_req;
    logic [31:0] lsu_addr_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_wr_i;
    logic [31:0] lsu_wr_data_i;
    logic        lsu_zero_extnd_i;
    logic        lsu_busy_o;
    logic        lsu_done_o;
    logic        lsu_err_o;
    logic [31:0] lsu_rd_data_o;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic [31:0] mem_addr_o;
    logic        mem_wr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wr_data_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rd_data_i;
    logic        mem_err_i;
    logic        d0_busy;
    logic        d0_done;
    logic        d0_err;
    logic [31:0] d0_rd;
    logic        d0_req;
    logic [31:0] d0_addr;
    logic        d0_wr;
    logic [3:0]  d0_be;
    logic [31:0] d0_wd;
    logic        d0_req_seen = 1'b0;

    int          n_pass = 0;
    int          n_total = 0;
    req_t        exp_q[$];
    res_t        res_q[$];
    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    riscv_lsu_ctrl #(.MISALIGN_SPLIT(1), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .lsu_req_i(lsu_req_i), .lsu_addr_i(lsu_addr_i),
        .lsu_size_i(lsu_size_i), .lsu_wr_i(lsu_wr_i), .lsu_wr_data_i(lsu_wr_data_i),
        .lsu_zero_extnd_i(lsu_zero_extnd_i), .lsu_busy_o(lsu_busy_o), .lsu_done_o(lsu_done_o),
        .lsu_err_o(lsu_err_o), .lsu_rd_data_o(lsu_rd_data_o), .mem_req_o(mem_req_o),
        .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_wr_o(mem_wr_o), .mem_be_o(mem_be_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_rvalid_i(mem_rvalid_i), .mem_rd_data_i(mem_rd_data_i),
        .mem_err_i(mem_err_i)
    );

    riscv_lsu_ctrl #(.MISALIGN_SPLIT(0), .TIMEOUT(8)) dut0 (
        .clk(clk), .reset(reset), .lsu_req_i(r0_req), .lsu_addr_i(lsu_addr_i),
        .lsu_size_i(lsu_size_i), .lsu_wr_i(lsu_wr_i), .lsu_wr_data_i(lsu_wr_data_i),
        .lsu_zero_extnd_i(lsu_zero_extnd_i), .lsu_busy_o(d0_busy), .lsu_done_o(d0_done),
        .lsu_err_o(d0_err), .lsu_rd_data_o(d0_rd), .mem_req_o(d0_req),
        .mem_gnt_i(mem_gnt_i), .mem_addr_o(d0_addr), .mem_wr_o(d0_wr), .mem_be_o(d0_be),
        .mem_wr_data_o(d0_wd), .mem_rvalid_i(mem_rvalid_i), .mem_rd_data_i(mem_rd_data_i),
        .mem_err_i(mem_err_i)
    );

    always @(posedge clk) if (d0_req) d0_req_seen <= 1'b1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic run(input logic [31:0] addr, input logic [1:0] size, input logic wr,
                       input logic [31:0] wd, input logic zext, input int gnt_wait,
                       input bit rv_en, input bit berr);
        int          c = 0;
        int          waited = 0;
        bit          pend = 0;
        logic [31:0] pa = '0;
        logic [31:0] w;
        res_t        r;
        lsu_addr_i = addr; lsu_size_i = size; lsu_wr_i = wr;
        lsu_wr_data_i = wd; lsu_zero_extnd_i = zext; lsu_req_i = 1'b1;
        #1;
        check("busy_accept", 32'(lsu_busy_o), 32'd1);
        while (c <= 40) begin
            step();
            c++;
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
            if (lsu_done_o) break;
            check("busy_active", 32'(lsu_busy_o), 32'd1);
            if (pend) begin
                pend = 0;
                if (rv_en) begin
                    mem_rvalid_i = 1'b1; mem_err_i = berr; mem_rd_data_i = rd_word(pa);
                end
            end
            if (mem_req_o) begin
                if (exp_q.size() == 0) check("unexpected_req", 32'(mem_req_o), 32'd0);
                else begin
                    check("req_addr", mem_addr_o, exp_q[0].addr);
                    check("req_be", 32'(mem_be_o), 32'(exp_q[0].be));
                    check("req_wr", 32'(mem_wr_o), 32'(exp_q[0].wr));
                    check("req_wdata", mem_wr_data_o, exp_q[0].wd);
                    if (waited < gnt_wait) waited++;
                    else begin
                        void'(exp_q.pop_front());
                        mem_gnt_i = 1'b1; pend = 1; pa = mem_addr_o; waited = 0;
                        if (mem_wr_o) begin
                            w = rd_word(pa);
                            for (int i = 0; i < 4; i++) if (mem_be_o[i]) w[8*i +: 8] = mem_wr_data_o[8*i +: 8];
                            mem[pa] = w;
                        end
                    end
                end
            end
        end
        check("done_seen", 32'(lsu_done_o), 32'd1);
        lsu_req_i = 1'b0;
        r = res_q.pop_front();
        check("err", 32'(lsu_err_o), 32'(r.err));
        check("rd_data", lsu_rd_data_o, r.rd);
        check("latency", 32'(c), 32'(r.lat));
        check("busy_done", 32'(lsu_busy_o), 32'd0);
        check("reqs_left", 32'(exp_q.size()), 32'd0);
        step();
        check("done_pulse", 32'(lsu_done_o), 32'd0);
    endtask

    initial begin
        reset = 1'b1; lsu_req_i = 0; r0_req = 0; lsu_addr_i = 0; lsu_size_i = 0; lsu_wr_i = 0;
        lsu_wr_data_i = 0; lsu_zero_extnd_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
        mem_rd_data_i = 0; mem_err_i = 0;
        mem[32'h100] = 32'h80FF_1234;
        mem[32'h1000] = 32'hAABB_CCDD;
        mem[32'h1004] = 32'h1122_3344;
        mem[32'h10] = 32'h1234_5678;
        repeat (3) step();
        reset = 1'b0;
        check("rst_busy", 32'(lsu_busy_o), 32'd0);
        check("rst_done", 32'(lsu_done_o), 32'd0);
        check("rst_err", 32'(lsu_err_o), 32'd0);
        check("rst_rd", lsu_rd_data_o, 32'd0);
        check("rst_req", 32'(mem_req_o), 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_be", 32'(mem_be_o), 32'd0);
        check("rst_wr", 32'(mem_wr_o), 32'd0);
        check("rst_wdata", mem_wr_data_o, 32'd0);
        exp_q.push_back('{32'h100, 4'b1000, 1'b0, 32'h0});
        res_q.push_back('{1'b0, 32'hFFFF_FF80, 3});
        run(32'h103, 2'd0, 1'b0, 32'h0, 1'b0, 0, 1, 0);
        exp_q.push_back('{32'h100, 4'b1000, 1'b0, 32'h0});
        res_q.push_back('{1'b0, 32'h0000_0080, 3});
        run(32'h103, 2'd0, 1'b0, 32'h0, 1'b1, 0, 1, 0);
        exp_q.push_back('{32'h1000, 4'b1000, 1'b0, 32'h0});
        exp_q.push_back('{32'h1004, 4'b0001, 1'b0, 32'h0});
        res_q.push_back('{1'b0, 32'h0000_44AA, 5});
        run(32'h1003, 2'd1, 1'b0, 32'h0, 1'b1, 0, 1, 0);
        exp_q.push_back('{32'h2000, 4'b1100, 1'b1, 32'hBEEF_0000});
        exp_q.push_back('{32'h2004, 4'b0011, 1'b1, 32'h0000_DEAD});
        res_q.push_back('{1'b0, 32'h0000_44AA, 5});
        run(32'h2002, 2'd2, 1'b1, 32'hDEAD_BEEF, 1'b0, 0, 1, 0);
        exp_q.push_back('{32'h2000, 4'b1100, 1'b0, 32'h0});
        exp_q.push_back('{32'h2004, 4'b0011, 1'b0, 32'h0});
        res_q.push_back('{1'b0, 32'hDEAD_BEEF, 5});
        run(32'h2002, 2'd2, 1'b0, 32'h0, 1'b0, 0, 1, 0);
        exp_q.push_back('{32'h100, 4'b1111, 1'b0, 32'h0});
        res_q.push_back('{1'b1, 32'hDEAD_BEEF, 3});
        run(32'h100, 2'd2, 1'b0, 32'h0, 1'b0, 0, 1, 1);
        exp_q.push_back('{32'h4000, 4'b1111, 1'b0, 32'h0});
        res_q.push_back('{1'b1, 32'hDEAD_BEEF, 10});
        run(32'h4000, 2'd2, 1'b0, 32'h0, 1'b0, 0, 0, 0);
        mem_rvalid_i = 1'b1; mem_rd_data_i = 32'h5555_5555;
        step();
        mem_rvalid_i = 1'b0;
        check("late_rv_done", 32'(lsu_done_o), 32'd0);
        check("late_rv_busy", 32'(lsu_busy_o), 32'd0);
        check("late_rv_rd", lsu_rd_data_o, 32'hDEAD_BEEF);
        lsu_addr_i = 32'h3001; lsu_size_i = 2'd2; lsu_wr_i = 1'b0; r0_req = 1'b1;
        step();
        r0_req = 1'b0;
        check("rej_done", 32'(d0_done), 32'd1);
        check("rej_err", 32'(d0_err), 32'd1);
        check("rej_busy", 32'(d0_busy), 32'd0);
        step();
        check("rej_pulse", 32'(d0_done), 32'd0);
        check("rej_no_req", 32'(d0_req_seen), 32'd0);
        lsu_addr_i = 32'h20; lsu_size_i = 2'd2; lsu_req_i = 1'b1;
        step();
        mem_gnt_i = 1'b1;
        step();
        mem_gnt_i = 1'b0; lsu_req_i = 1'b0;
        check("mid_busy", 32'(lsu_busy_o), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0; mem_rvalid_i = 1'b1; mem_rd_data_i = 32'hFFFF_FFFF;
        check("mid_rst_req", 32'(mem_req_o), 32'd0);
        check("mid_rst_busy", 32'(lsu_busy_o), 32'd0);
        check("mid_rst_rd", lsu_rd_data_o, 32'd0);
        check("mid_rst_be", 32'(mem_be_o), 32'd0);
        step();
        mem_rvalid_i = 1'b0;
        check("stale_done", 32'(lsu_done_o), 32'd0);
        check("stale_err", 32'(lsu_err_o), 32'd0);
        check("stale_busy", 32'(lsu_busy_o), 32'd0);
        exp_q.push_back('{32'h10, 4'b1111, 1'b0, 32'h0});
        res_q.push_back('{1'b0, 32'h1234_5678, 6});
        run(32'h10, 2'd2, 1'b0, 32'h0, 1'b0, 3, 1, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/riscv_lsu_ctrl.md
Name: riscv_lsu_ctrl

Overview:
Sequential load/store controller between the core's data-access signals and a word-aligned memory port with a req/gnt/rvalid handshake. It generates byte enables and aligns write data by lane, and performs load sign/zero extension. It tolerates variable memory latency and optionally splits misaligned accesses into two word transactions. It replaces the pass-through data-memory interface and adds a core stall, error reporting and a response timeout.

Parameters:
MISALIGN_SPLIT, 1, 1 = split misaligned access into two word transactions; 0 = reject with lsu_err_o, no memory access
TIMEOUT, 255, max cycles waiting for mem_rvalid_i per transaction; 0 disables timeout
TO_W, $clog2(TIMEOUT+1), timeout counter width (derived)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
lsu_req_i  in  1  core access request, held until lsu_done_o
lsu_addr_i  in  32  byte address
lsu_size_i  in  2  access size, riscv_pkg encoding (Byte_Access, Halfword_Access, Word_Access, Reserved)
lsu_wr_i  in  1  1 = store, 0 = load
lsu_wr_data_i  in  32  store data, right-justified
lsu_zero_extnd_i  in  1  load zero-extend (1) / sign-extend (0)
lsu_busy_o  out  1  core stall
lsu_done_o  out  1  one-cycle completion pulse
lsu_err_o  out  1  valid with lsu_done_o: misaligned-reject, bus error or timeout
lsu_rd_data_o  out  32  extended load result, registered
mem_req_o  out  1  memory request, held until mem_gnt_i
mem_gnt_i  in  1  memory accepted request
mem_addr_o  out  32  word-aligned address, [1:0]=0
mem_wr_o  out  1  write enable
mem_be_o  out  4  byte-lane enables
mem_wr_data_o  out  32  lane-aligned write data
mem_rvalid_i  in  1  response valid, for reads and writes
mem_rd_data_i  in  32  read word
mem_err_i  in  1  bus error, qualified by mem_rvalid_i

Behaviour:
- Reset: state=IDLE, every output 0, capture regs and timeout counter 0.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE.
- Size bytes: Byte=1, Halfword=2, Word=4, Reserved=4 (treated as Word). off=addr[1:0].
- Misaligned when off+bytes>4.
- IDLE: when lsu_req_i is high, latch addr/size/wr/data/zext.
  - Misaligned and MISALIGN_SPLIT=0 -> DONE with err=1, no mem_req_o.
  - Otherwise -> REQ0.
- REQ0: mem_req_o=1, addr={a[31:2],2'b00}, be=(bytemask<<off)[3:0], wdata=data<<(8*off). Hold stable until mem_gnt_i, then -> WAIT0.
- WAIT0: on mem_rvalid_i, capture word0.
  - mem_err_i -> DONE err=1.
  - Split needed -> REQ1.
  - Otherwise -> DONE.
- REQ1: addr=word0 addr+4 (32-bit wrap), be=(bytemask<<off)[7:4], wdata=data>>(8*(4-off)). On gnt -> WAIT1.
- WAIT1: on rvalid, capture word1 -> DONE; error handling as in WAIT0.
- DONE: lsu_done_o=1 and lsu_err_o set for one cycle, then -> IDLE. lsu_req_i is ignored in DONE; the next request is accepted in IDLE.
- Load result: {word1,word0}>>(8*off), low `bytes` bytes, extended per zext. A Byte load at 0x80 gives 0xFFFF_FF80 when signed and 0x0000_0080 when zero-extended.
- lsu_rd_data_o updates only on a successful load completion. It holds on stores and errors.
- lsu_busy_o = (IDLE & lsu_req_i) | state in {REQ0,WAIT0,REQ1,WAIT1}. It is 0 in DONE.
- Timing:
  - Minimum aligned latency: accept at cycle 0, gnt at cycle 1, rvalid at cycle 2, done at cycle 3.
  - Split access adds 2 cycles.
- Memory contract:
  - rvalid arrives no earlier than the cycle after gnt.
  - rvalid/gnt outside WAIT*/REQ* states are ignored, including stale responses after reset.
- Timeout: counter clears on entering WAIT*, increments each WAIT cycle without rvalid. At TIMEOUT -> DONE err=1.
- Reset mid-operation: next edge returns to IDLE. mem_req_o drops and the transaction is abandoned.

Decomposition:
- riscv_pkg: lsu_state_t enum; existing access-size enum; size-to-bytemask function.
- Sub-module riscv_lsu_align (combinational):
  - store lane shift and byte enables per half;
  - 64-bit load extraction and extension.
- FSM and timeout counter stay in riscv_lsu_ctrl.

Test Plan:
1. Signed LB at 0x103, word 0x80FF_1234, gnt same cycle, rvalid +1 -> mem_be_o=4'b1000, lsu_rd_data_o=0xFFFF_FF80, done 3 cycles after accept.
2. LHU at 0x1003 with SPLIT=1, words 0xAABBCCDD@0x1000 and 0x11223344@0x1004 -> be 1000 then 0001, addr 0x1000 then 0x1004, result 0x0000_44AA.
3. SW 0xDEADBEEF at 0x2002 with SPLIT=1 -> req0 addr 0x2000 be 1100 wdata 0xBEEF0000; req1 addr 0x2004 be 0011 wdata 0x0000DEAD; lsu_rd_data_o unchanged.
4. LW at 0x3001 with SPLIT=0 -> mem_req_o never asserted, done+err one cycle after accept.
5. TIMEOUT=8, LW 0x4000, gnt given, rvalid withheld -> err after 8 WAIT0 cycles; a late rvalid is ignored.
6. Reset in WAIT0, then rvalid arrives -> all outputs 0, state IDLE, no done pulse; a following LW 0x10 with mem_gnt_i withheld 3 cycles keeps mem_req_o/addr/be stable, then completes normally.
